// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment display: segment patterns,
// converter FSM states and a power-of-ten helper for the overflow threshold.
package seg_scan_pkg;

    typedef enum logic {IDLE, CONV} conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low gfedcba patterns; entry n is the glyph for digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        if (nib > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD engine (module bin2bcd_seq): one shift per
// clock, VALUE_WIDTH clocks per conversion, load accepted only while idle.
module bin2bcd_seq
    import seg_scan_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 14,
    parameter int unsigned NUM_DIGITS  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_load,
    input  logic [VALUE_WIDTH-1:0]      i_value,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [4*NUM_DIGITS-1:0]     o_bcd
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned SR_W  = BCD_W + VALUE_WIDTH;
    localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE_WIDTH - 1);

    conv_state_t       r_state;
    conv_state_t       w_state_next;
    logic [SR_W-1:0]   r_sr;
    logic [SR_W-1:0]   w_sr_adj;
    logic [SR_W-1:0]   w_sr_shift;
    logic [CNT_W-1:0]  r_cnt;

    always_comb begin
        w_sr_adj = r_sr;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (r_sr[VALUE_WIDTH + 4*d +: 4] >= 4'd5) begin
                w_sr_adj[VALUE_WIDTH + 4*d +: 4] = r_sr[VALUE_WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        w_sr_shift = {w_sr_adj[SR_W-2:0], 1'b0};
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_state_next = CONV;
                end
            end
            CONV: begin
                o_busy = 1'b1;
                if (r_cnt == LAST) begin
                    o_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The result is taken from the final shift combinationally so the display
    // register can load it on the same edge that returns the FSM to idle.
    assign o_bcd = w_sr_shift[SR_W-1 -: BCD_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE) begin
                if (i_load) begin
                    r_sr  <= {{BCD_W{1'b0}}, i_value};
                    r_cnt <= '0;
                end
            end else begin
                r_sr  <= w_sr_shift;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment driver with sequential BCD conversion.
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned VALUE_WIDTH = 14,
    parameter int unsigned REFRESH_DIV = 10000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VALUE_WIDTH-1:0]  value,
    input  logic                    load,
    output logic                    busy,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    w_busy;
    logic                    w_done;
    logic                    w_start;
    logic                    w_ovf_in;
    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic                    r_ovf_pend;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic                    r_ovf;

    logic [CNT_W-1:0]        r_cnt;
    logic                    w_wrap;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_next;
    logic                    r_started;
    logic                    w_started_next;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic                    w_nz;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic [6:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    bin2bcd_seq #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .i_load  (load),
        .i_value (value),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    assign busy     = w_busy;
    assign w_start  = load & ~w_busy;
    assign w_ovf_in = (64'(value) >= pow10(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_start) begin
                r_ovf_pend <= w_ovf_in;
            end
            if (w_done) begin
                r_bcd <= w_bcd;
                r_ovf <= r_ovf_pend;
            end
        end
    end

    assign w_wrap         = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_started_next = r_started | w_wrap;

    // The first wrap after reset lights digit 0 rather than advancing past it.
    always_comb begin
        w_idx_next = r_idx;
        if (w_wrap && r_started) begin
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                w_idx_next = '0;
            end else begin
                w_idx_next = r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_lz = '0;
        w_nz = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        for (int unsigned d = NUM_DIGITS - 1; d > 0; d--) begin
            w_nz    = w_nz | (r_bcd[4*d +: 4] != 4'd0);
            w_lz[d] = ~w_nz;
        end
`else
        w_nz = 1'b1;
`endif
    end

    always_comb begin
        w_nib   = '0;
        w_blank = 1'b0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (w_idx_next == IDX_W'(d)) begin
                w_nib   = r_bcd[4*d +: 4];
                w_blank = w_lz[d];
            end
        end
        if (r_ovf) begin
            w_seg_next = SEG_DASH;
        end else if (w_blank) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = seg_decode(w_nib);
        end
        w_an_next = ~(NUM_DIGITS'(1) << w_idx_next);
    end

    // seg and an come from the same next-index so they always switch together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_started <= 1'b0;
            r_seg     <= SEG_BLANK;
            r_an      <= '1;
        end else begin
            r_cnt     <= w_wrap ? '0 : r_cnt + 1'b1;
            r_idx     <= w_idx_next;
            r_started <= w_started_next;
            if (w_started_next) begin
                r_seg <= w_seg_next;
                r_an  <= w_an_next;
            end
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised multiplexed seven-segment driver, successor to the fixed 4-digit two-field display controller. Accepts one unsigned binary value and converts it to BCD with a sequential double-dabble engine (load/busy handshake). It scans NUM_DIGITS digits with a programmable refresh divider. Sits between game/score logic and the board's common-anode display pins.

Parameters:
NUM_DIGITS, 4, number of digits and anodes driven (1..8)
VALUE_WIDTH, 14, width of binary input value
REFRESH_DIV, 10000, clk cycles each digit stays enabled (>=2)

Ports:
clk  input  1  system clock (5 MHz on board)
reset  input  1  synchronous, active-high reset
value  input  VALUE_WIDTH  unsigned binary number to show
load  input  1  one-cycle strobe; captures value when busy=0
busy  output  1  conversion in progress; load ignored while high
seg  output  7  segment drive, active-low, bit0=a .. bit6=g
an  output  NUM_DIGITS  anode enables, active-low, bit0 = rightmost (ones) digit

Behaviour:
- Reset: busy=0; seg=7'h7F; an=all ones; digit index=0; refresh counter=0; display BCD register=0; overflow flag=0. The first scan after reset shows a single "0" on digit 0.
- Converter FSM, two states:
  - IDLE: on load=1, capture value and set ovf = (value >= 10**NUM_DIGITS). Clear the shift register {BCD[4*NUM_DIGITS], bin[VALUE_WIDTH]}. Go to CONV. busy goes high the next cycle.
  - CONV: VALUE_WIDTH iterations, one per clk. Each iteration adds 3 to every BCD nibble >=5, then shifts the whole register left by 1.
  - After the last iteration, the display register and overflow flag update together and the FSM returns to IDLE. busy falls in the same cycle.
  - Latency: load at cycle 0; busy high cycles 1..VALUE_WIDTH; new digits visible from cycle VALUE_WIDTH+1.
- load while busy: ignored, no queuing. load is level-sampled in IDLE only; holding it high restarts conversion immediately after completion.
- The display register keeps its old contents throughout a conversion. There are no partial updates.
- Scanner:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances by one. It wraps from NUM_DIGITS-1 to 0.
  - an = ~(1 << index), exactly one anode low at any time after reset.
  - seg is registered and aligned with an in the same cycle. There is no ghosting cycle where a new anode shows an old segment pattern.
- Segment map, active-low, standard 0-9 (e.g. 0=7'b1000000, 4=7'b0011001, 8=7'b0000000). Nibble values 10-15 cannot occur and decode to blank (7'h7F).
- Overflow: when ovf=1, every digit shows a dash (7'b0111111). This overrides leading-zero blanking.
- Reset mid-conversion: the conversion is aborted, busy=0 next cycle, and the display returns to "0".

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: any digit at index >0 whose nibble and all higher nibbles are zero shows seg=7'h7F, with its anode still scanned. Digit 0 always shows its value.
- Undefined: all digits shown, zero-padded (7 -> "0007").

Decomposition:
- Package seg_scan_pkg holds:
  - the segment-pattern constants (SEG_BLANK, SEG_DASH, 0-9 table);
  - the converter FSM state typedef (IDLE, CONV);
  - a function returning 10**n, used for the overflow threshold.
- One sub-module is natural: bin2bcd_seq, the double-dabble engine with a load/busy/done interface. The scanner and segment decode stay in the top level.

Test Plan:
1. Reset, no load -> busy=0; after the first refresh period an=4'b1110, seg=7'b1000000. The anode rotates 1110->1101->1011->0111->1110 every REFRESH_DIV cycles (run with REFRESH_DIV=4).
2. load value=1234 -> busy=1 for exactly 14 cycles. Then the scan shows an=1110 seg='4' (7'b0011001), an=1101 '3', an=1011 '2', an=0111 '1'.
3. load 7 with macro defined -> digits 1-3 seg=7'h7F, digit 0 '7'. Without the macro -> digits 1-3 show '0'.
4. load 12000 (>9999) -> all four digits show 7'b0111111. A subsequent load of 9999 -> "9999", dashes cleared.
5. load 55 then load 66 on cycle 3 while busy -> 66 ignored, display "55", busy timing unchanged.
6. Assert reset at cycle 5 of a conversion of 4321 -> busy=0 next cycle, display "0", an=all ones until the next scan step. A new load converts normally.
